// File: rtl/avalon_master_bridge.sv
// avalon_master_bridge
// Turns single CPU load/store requests into Avalon-MM read/write transfers,
// one at a time. Handles byte-lane alignment, byteenable generation,
// write-data replication and sign/zero extension of load results.
//
// Ports
//   clk, rst_n            : clock, async active-low reset
//   req_*                 : CPU request (valid/ready handshake, sampled at accept)
//   resp_valid/rdata/err  : one-cycle response pulse per request
//   address..writedata    : Avalon-MM master outputs (all registered)
//   waitrequest, readdata : Avalon-MM slave inputs
//   wait_count            : waitrequest-high cycles of last completed transfer
//
// state  | meaning
// IDLE   | req_ready=1, waiting for a CPU request
// BUS    | read/write asserted, waiting for waitrequest=0
// RESP   | resp_valid pulse, then back to IDLE
module avalon_master_bridge #(
  parameter int WAIT_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [31:0]           address,
  output logic [3:0]            byteenable,
  output logic                  read,
  output logic                  write,
  output logic [31:0]           writedata,
  input  logic                  waitrequest,
  input  logic [31:0]           readdata,
  output logic [WAIT_CNT_W-1:0] wait_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [WAIT_CNT_W-1:0] CNT_ONE = {{(WAIT_CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]            state_q, state_d;
  logic                  read_q, read_d;
  logic                  write_q, write_d;
  logic [31:0]           address_q, address_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]            lane_q, lane_d;
  logic [1:0]            size_q, size_d;
  logic                  signed_q, signed_d;

  logic                  illegal;
  logic [3:0]            be_calc;
  logic [31:0]           wd_calc;
  logic [31:0]           rd_shift;
  logic [31:0]           rd_ext;

  assign illegal = (req_size == 2'd3)
                 | ((req_size == 2'd1) & req_addr[0])
                 | ((req_size == 2'd2) & (req_addr[1:0] != 2'b00));

  always_comb begin
    be_calc = 4'b1111;
    wd_calc = req_wdata;
    case (req_size)
      2'd0: begin
        be_calc = 4'b0001 << req_addr[1:0];
        wd_calc = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        be_calc = req_addr[1] ? 4'b1100 : 4'b0011;
        wd_calc = {2{req_wdata[15:0]}};
      end
      default: begin
        be_calc = 4'b1111;
        wd_calc = req_wdata;
      end
    endcase
  end

  // Lane captured at accept moves the addressed byte/half down to bit 0.
  assign rd_shift = readdata >> {lane_q, 3'b000};

  always_comb begin
    rd_ext = readdata;
    case (size_q)
      2'd0:    rd_ext = {{24{signed_q & rd_shift[7]}}, rd_shift[7:0]};
      2'd1:    rd_ext = {{16{signed_q & rd_shift[15]}}, rd_shift[15:0]};
      default: rd_ext = readdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    read_d       = read_q;
    write_d      = write_q;
    address_d    = address_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'h0;
    wait_cnt_d   = wait_cnt_q;
    lane_d       = lane_q;
    size_d       = size_q;
    signed_d     = signed_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (illegal) begin
            // Errored requests never touch the bus or wait_count.
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d    = S_BUS;
            read_d     = ~req_write;
            write_d    = req_write;
            address_d  = {req_addr[31:2], 2'b00};
            be_d       = be_calc;
            wdata_d    = wd_calc;
            wait_cnt_d = '0;
            lane_d     = req_addr[1:0];
            size_d     = req_size;
            signed_d   = req_signed;
          end
        end
      end
      S_BUS: begin
        if (waitrequest) begin
          if (wait_cnt_q != {WAIT_CNT_W{1'b1}})
            wait_cnt_d = wait_cnt_q + CNT_ONE;
        end else begin
          state_d      = S_RESP;
          read_d       = 1'b0;
          write_d      = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = read_q ? rd_ext : 32'h0;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      address_q    <= 32'h0;
      be_q         <= 4'h0;
      wdata_q      <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      wait_cnt_q   <= '0;
      lane_q       <= 2'b00;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      read_q       <= read_d;
      write_q      <= write_d;
      address_q    <= address_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      wait_cnt_q   <= wait_cnt_d;
      lane_q       <= lane_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign address    = address_q;
  assign byteenable = be_q;
  assign read       = read_q;
  assign write      = write_q;
  assign writedata  = wdata_q;
  assign wait_count = wait_cnt_q;

endmodule

// File: tb/tb_avalon_master_bridge.sv
// Directed bench for avalon_master_bridge. Expected responses are queued
// when a request is driven and popped when resp_valid appears.
module tb_avalon_master_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] address, writedata, readdata;
  logic [3:0]  byteenable;
  logic        read, write, waitrequest;
  logic [15:0] wait_count;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [15:0] wc;
  } exp_t;

  exp_t        sb[$];
  int          compared = 0;
  int          mismatched = 0;
  logic [15:0] last_wc = 16'h0;

  avalon_master_bridge #(.WAIT_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .address(address), .byteenable(byteenable), .read(read), .write(write),
    .writedata(writedata), .waitrequest(waitrequest), .readdata(readdata),
    .wait_count(wait_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_req(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] wd, input logic [31:0] rd,
                         input int nwait, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                         input logic [31:0] exp_rdata, input logic exp_err);
    exp_t e;
    int   k;
    @(negedge clk);
    check("ready_idle", 32'(req_ready), 32'd1);
    req_valid   = 1'b1;
    req_write   = wr;
    req_addr    = addr;
    req_size    = size;
    req_signed  = sgn;
    req_wdata   = wd;
    waitrequest = (nwait > 0);
    readdata    = rd;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    if (!exp_err) last_wc = 16'(nwait);
    e.wc = last_wc;
    sb.push_back(e);
    @(negedge clk);
    // Scramble request inputs; the bridge must use only what it sampled.
    req_valid  = 1'b0;
    req_write  = ~wr;
    req_addr   = 32'hFFFF_FFFF;
    req_size   = 2'd0;
    req_signed = ~sgn;
    req_wdata  = ~wd;
    if (!exp_err) begin
      for (int i = 0; i <= nwait; i++) begin
        check("strobe", 32'({read, write}), wr ? 32'd1 : 32'd2);
        check("byteenable", 32'(byteenable), 32'(exp_be));
        check("address", address, {addr[31:2], 2'b00});
        if (wr) check("writedata", writedata, exp_wd);
        check("no_resp_in_bus", 32'(resp_valid), 32'd0);
        if (i < nwait) @(negedge clk);
      end
      waitrequest = 1'b0;
    end
    k = 0;
    while (!resp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("resp_latency", 32'(k), exp_err ? 32'd0 : 32'd1);
    check("resp_valid", 32'(resp_valid), 32'd1);
    check("strobe_off", 32'({read, write}), 32'd0);
    if (resp_valid && sb.size() > 0) begin
      e = sb.pop_front();
      check("resp_rdata", resp_rdata, e.rdata);
      check("resp_err", 32'(resp_err), 32'(e.err));
      check("wait_count", 32'(wait_count), 32'(e.wc));
    end
    @(negedge clk);
    check("resp_pulse_end", 32'(resp_valid), 32'd0);
    check("rdata_idle_zero", resp_rdata, 32'd0);
    check("err_idle_zero", 32'(resp_err), 32'd0);
    check("ready_after", 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_size = 2'd0;
    req_signed = 1'b0; req_wdata = 32'h0; waitrequest = 1'b0; readdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_strobes", 32'({read, write}), 32'd0);
    check("rst_resp", 32'({resp_valid, resp_err}), 32'd0);
    check("rst_address", address, 32'd0);
    check("rst_be", 32'(byteenable), 32'd0);
    check("rst_wdata", writedata, 32'd0);
    check("rst_wc", 32'(wait_count), 32'd0);
    rst_n = 1'b1;

    //      wr    addr          sz    sgn   wdata         readdata      nw be       exp_wd        exp_rdata     err
    run_req(1'b0, 32'h0000_1000, 2'd2, 1'b0, 32'h0,        32'hDEAD_BEEF, 0, 4'b1111, 32'h0,        32'hDEAD_BEEF, 1'b0);
    run_req(1'b0, 32'h0000_1003, 2'd0, 1'b1, 32'h0,        32'h80FF_0000, 3, 4'b1000, 32'h0,        32'hFFFF_FF80, 1'b0);
    run_req(1'b0, 32'h0000_1002, 2'd1, 1'b0, 32'h0,        32'h80FF_0000, 1, 4'b1100, 32'h0,        32'h0000_80FF, 1'b0);
    run_req(1'b1, 32'h0000_2001, 2'd0, 1'b0, 32'h0000_00A5, 32'h5555_5555, 2, 4'b0010, 32'hA5A5_A5A5, 32'h0,        1'b0);
    run_req(1'b0, 32'h0000_2002, 2'd2, 1'b0, 32'h0,        32'h1111_1111, 0, 4'b0000, 32'h0,        32'h0,         1'b1);
    run_req(1'b0, 32'h0000_2000, 2'd3, 1'b0, 32'h0,        32'h1111_1111, 0, 4'b0000, 32'h0,        32'h0,         1'b1);
    run_req(1'b1, 32'h0000_2001, 2'd1, 1'b0, 32'h0000_BEEF, 32'h0,        0, 4'b0000, 32'h0,        32'h0,         1'b1);
    run_req(1'b0, 32'h0000_1000, 2'd1, 1'b1, 32'h0,        32'h1234_8001, 0, 4'b0011, 32'h0,        32'hFFFF_8001, 1'b0);
    run_req(1'b0, 32'h0000_1003, 2'd0, 1'b0, 32'h0,        32'h80FF_0000, 0, 4'b1000, 32'h0,        32'h0000_0080, 1'b0);
    run_req(1'b0, 32'h0000_1004, 2'd0, 1'b1, 32'h0,        32'hFFFF_FF7F, 0, 4'b0001, 32'h0,        32'h0000_007F, 1'b0);
    run_req(1'b0, 32'h0000_1008, 2'd2, 1'b1, 32'h0,        32'h8000_0001, 0, 4'b1111, 32'h0,        32'h8000_0001, 1'b0);
    run_req(1'b1, 32'h0000_3002, 2'd1, 1'b0, 32'h1234_BEEF, 32'h0,        1, 4'b1100, 32'hBEEF_BEEF, 32'h0,        1'b0);
    run_req(1'b1, 32'h0000_3000, 2'd2, 1'b0, 32'h1234_5678, 32'h0,        4, 4'b1111, 32'h1234_5678, 32'h0,        1'b0);

    // Reset while stalled in BUS.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_4000; req_size = 2'd2;
    waitrequest = 1'b1; readdata = 32'hCAFE_F00D;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_read_high", 32'(read), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_read_drop", 32'(read), 32'd0);
    check("abort_write_low", 32'(write), 32'd0);
    check("abort_wc_clear", 32'(wait_count), 32'd0);
    check("abort_addr_clear", address, 32'd0);
    check("abort_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_resp", 32'(resp_valid), 32'd0);
    end
    rst_n = 1'b1;
    waitrequest = 1'b0;
    last_wc = 16'h0;
    @(negedge clk);
    check("post_rst_no_resp", 32'(resp_valid), 32'd0);
    run_req(1'b0, 32'h0000_4002, 2'd1, 1'b1, 32'h0, 32'h7FFF_0000, 2, 4'b1100, 32'h0, 32'h0000_7FFF, 1'b0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
